// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, 64-bit ALU, and the EX/MEM pipeline register.
// Latency: one cycle from ID/EX inputs to the registered EX/MEM outputs.
// Backpressure: stall holds the EX/MEM register; flush turns it into a bubble (flush wins).
module ex_stage #(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic            alu_src_in,
    input  logic            mem_to_reg_in,
    input  logic            reg_write_in,
    input  logic            mem_read_in,
    input  logic            mem_write_in,
    input  logic [1:0]      alu_op_in,
    input  logic [3:0]      funct_in,
    input  logic [XLEN-1:0] rs1_data_in,
    input  logic [XLEN-1:0] rs2_data_in,
    input  logic [REGW-1:0] rs_in,
    input  logic [REGW-1:0] rt_in,
    input  logic [REGW-1:0] rd_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            wb_reg_write,
    input  logic [REGW-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            stall,
    input  logic            flush,
    output logic            valid_out,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic [XLEN-1:0] alu_result_out,
    output logic [XLEN-1:0] store_data_out,
    output logic [REGW-1:0] rd_out,
    output logic            zero_out
);

    // EX/MEM register state
    logic            valid_q, mem_to_reg_q, reg_write_q, mem_read_q, mem_write_q, zero_q;
    logic            valid_d, mem_to_reg_d, reg_write_d, mem_read_d, mem_write_d, zero_d;
    logic [XLEN-1:0] alu_result_q, store_data_q, alu_result_d, store_data_d;
    logic [REGW-1:0] rd_q, rd_d;

    // Combinational datapath
    logic            exmem_fwd_ok;
    logic [XLEN-1:0] op_a, op_b_raw, op_b, alu_res;
    logic            is_rtype;

    // Operand forwarding: EX/MEM (non-load, non-x0) beats MEM/WB beats the register file
    always_comb begin
        exmem_fwd_ok = valid_q && reg_write_q && !mem_read_q && (rd_q != '0);

        op_a = rs1_data_in;
        if (exmem_fwd_ok && (rd_q == rs_in)) begin
            op_a = alu_result_q;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs_in)) begin
            op_a = wb_data;
        end

        op_b_raw = rs2_data_in;
        if (exmem_fwd_ok && (rd_q == rt_in)) begin
            op_b_raw = alu_result_q;
        end else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rt_in)) begin
            op_b_raw = wb_data;
        end

        op_b = alu_src_in ? imm_in : op_b_raw;
    end

    // ALU: I-type (op 11) ignores funct7[5] except to pick srl vs sra, and never subtracts
    always_comb begin
        alu_res  = '0;
        is_rtype = (alu_op_in == 2'b10);
        case (alu_op_in)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            default: begin
                case (funct_in[2:0])
                    3'b000: alu_res = (is_rtype && funct_in[3]) ? (op_a - op_b) : (op_a + op_b);
                    3'b111: alu_res = op_a & op_b;
                    3'b110: alu_res = op_a | op_b;
                    3'b100: alu_res = op_a ^ op_b;
                    3'b001: alu_res = (is_rtype && funct_in[3]) ? '0 : (op_a << op_b[5:0]);
                    3'b101: alu_res = funct_in[3] ? XLEN'($signed(op_a) >>> op_b[5:0])
                                                  : (op_a >> op_b[5:0]);
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // Next-state for EX/MEM: flush > stall > capture; a bubble carries no control
    always_comb begin
        valid_d      = valid_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        zero_d       = zero_q;
        alu_result_d = alu_result_q;
        store_data_d = store_data_q;
        rd_d         = rd_q;
        if (flush) begin
            valid_d      = 1'b0;
            mem_to_reg_d = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
        end else if (!stall) begin
            valid_d      = valid_in;
            mem_to_reg_d = valid_in & mem_to_reg_in;
            reg_write_d  = valid_in & reg_write_in;
            mem_read_d   = valid_in & mem_read_in;
            mem_write_d  = valid_in & mem_write_in;
            alu_result_d = alu_res;
            store_data_d = op_b_raw;
            rd_d         = rd_in;
            zero_d       = (alu_res == '0);
        end
    end

    // EX/MEM register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            zero_q       <= 1'b0;
            alu_result_q <= '0;
            store_data_q <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            zero_q       <= zero_d;
            alu_result_q <= alu_result_d;
            store_data_q <= store_data_d;
            rd_q         <= rd_d;
        end
    end

    assign valid_out      = valid_q;
    assign mem_to_reg_out = mem_to_reg_q;
    assign reg_write_out  = reg_write_q;
    assign mem_read_out   = mem_read_q;
    assign mem_write_out  = mem_write_q;
    assign zero_out       = zero_q;
    assign alu_result_out = alu_result_q;
    assign store_data_out = store_data_q;
    assign rd_out         = rd_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, stall/flush/reset behaviour.
// Inputs change 1 time unit after each rising edge; outputs are checked at the same point.
// No backpressure beyond the stall/flush inputs driven here.
module tb_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, alu_src_in, mem_to_reg_in, reg_write_in, mem_read_in, mem_write_in;
    logic [1:0]  alu_op_in;
    logic [3:0]  funct_in;
    logic [63:0] rs1_data_in, rs2_data_in, imm_in, wb_data;
    logic [4:0]  rs_in, rt_in, rd_in, wb_rd;
    logic        wb_reg_write, stall, flush;
    logic        valid_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, zero_out;
    logic [63:0] alu_result_out, store_data_out;
    logic [4:0]  rd_out;

    int n_chk = 0;
    int n_bad = 0;

    ex_stage #(.XLEN(64), .REGW(5)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in),
        .alu_src_in(alu_src_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .alu_op_in(alu_op_in), .funct_in(funct_in),
        .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .imm_in(imm_in),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall(stall), .flush(flush),
        .valid_out(valid_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .alu_result_out(alu_result_out), .store_data_out(store_data_out),
        .rd_out(rd_out), .zero_out(zero_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Default: a valid ALU op with no memory access, no writeback, no forwarding sources
    task automatic clr();
        valid_in = 1'b1; alu_src_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b0;
        mem_read_in = 1'b0; mem_write_in = 1'b0; alu_op_in = 2'b00; funct_in = 4'b0000;
        rs1_data_in = '0; rs2_data_in = '0; imm_in = '0;
        rs_in = 5'd1; rt_in = 5'd2; rd_in = 5'd0;
        wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic alu_vec(input string tag, input logic [1:0] op, input logic [3:0] fn,
                           input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        clr();
        alu_op_in = op; funct_in = fn; rs1_data_in = a; rs2_data_in = b;
        tick();
        chk(tag, alu_result_out, exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {59'd0, valid_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out}, 64'd0);
        chk({tag, "_alu"}, alu_result_out, 64'd0);
        chk({tag, "_sd"}, store_data_out, 64'd0);
        chk({tag, "_rd"}, {59'd0, rd_out}, 64'd0);
        chk({tag, "_zero"}, {63'd0, zero_out}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with busy inputs
        clr();
        rst = 1'b1;
        reg_write_in = 1'b1; mem_write_in = 1'b1; rs1_data_in = 64'd5; rd_in = 5'd3;
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // add x5 = 3 + 4
        clr();
        rs1_data_in = 64'd3; rs2_data_in = 64'd4; rd_in = 5'd5; reg_write_in = 1'b1;
        tick();
        chk("add_res", alu_result_out, 64'd7);
        chk("add_rd", {59'd0, rd_out}, 64'd5);
        chk("add_vld", {62'd0, valid_out, reg_write_out}, 64'd3);

        // sub x6 = x5 - x5 with stale register file values
        clr();
        alu_op_in = 2'b01; rs_in = 5'd5; rt_in = 5'd5;
        rs1_data_in = 64'd99; rs2_data_in = 64'd99; rd_in = 5'd6; reg_write_in = 1'b1;
        tick();
        chk("fwd_sub_res", alu_result_out, 64'd0);
        chk("fwd_sub_zero", {63'd0, zero_out}, 64'd1);

        // x7 = 10 in EX/MEM, MEM/WB writes x7 = 20: EX/MEM wins
        clr();
        rs1_data_in = 64'd10; rd_in = 5'd7; reg_write_in = 1'b1;
        tick();
        clr();
        rs_in = 5'd7; rt_in = 5'd0; rs1_data_in = 64'd1; rd_in = 5'd9;
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'd20;
        tick();
        chk("prio_exmem", alu_result_out, 64'd10);

        // Same setup targeting x0: neither source forwards
        clr();
        rs1_data_in = 64'd10; rd_in = 5'd0; reg_write_in = 1'b1;
        tick();
        clr();
        rs_in = 5'd0; rt_in = 5'd0; rs1_data_in = 64'd3;
        wb_reg_write = 1'b1; wb_rd = 5'd0; wb_data = 64'd20;
        tick();
        chk("x0_nofwd", alu_result_out, 64'd3);

        // ld x8 at 0x100 in EX/MEM; MEM/WB writes x8 = 55
        clr();
        alu_src_in = 1'b1; imm_in = 64'h100; rs_in = 5'd0; rd_in = 5'd8;
        mem_read_in = 1'b1; mem_to_reg_in = 1'b1; reg_write_in = 1'b1;
        tick();
        chk("ld_addr", alu_result_out, 64'h100);
        chk("ld_ctl", {61'd0, mem_to_reg_out, mem_read_out, mem_write_out}, 64'd6);
        clr();
        rs_in = 5'd8; rt_in = 5'd0; rs1_data_in = 64'd1;
        wb_reg_write = 1'b1; wb_rd = 5'd8; wb_data = 64'd55;
        tick();
        chk("ld_nofwd", alu_result_out, 64'd55);

        // addi x9 = 0xAB, then sd x9, 16(x1) with x1 = 0x40
        clr();
        alu_op_in = 2'b11; alu_src_in = 1'b1; imm_in = 64'hAB; rs_in = 5'd0;
        rd_in = 5'd9; reg_write_in = 1'b1;
        tick();
        chk("addi_res", alu_result_out, 64'hAB);
        clr();
        alu_src_in = 1'b1; imm_in = 64'd16; rs_in = 5'd1; rs1_data_in = 64'h40;
        rt_in = 5'd9; rs2_data_in = 64'd7; mem_write_in = 1'b1;
        tick();
        chk("sd_addr", alu_result_out, 64'h50);
        chk("sd_data", store_data_out, 64'hAB);
        chk("sd_memw", {62'd0, mem_write_out, reg_write_out}, 64'd2);

        // ALU op coverage
        alu_vec("sra", 2'b10, 4'b1101, 64'h8000_0000_0000_0000, 64'd4, 64'hF800_0000_0000_0000);
        alu_vec("srl", 2'b10, 4'b0101, 64'h8000_0000_0000_0000, 64'd4, 64'h0800_0000_0000_0000);
        alu_vec("sll", 2'b10, 4'b0001, 64'h8000_0000_0000_0000, 64'd4, 64'd0);
        alu_vec("sub_wrap", 2'b10, 4'b1000, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);
        alu_vec("add_r", 2'b10, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1);
        alu_vec("and", 2'b10, 4'b1111, 64'hF0, 64'h3C, 64'h30);
        alu_vec("or", 2'b10, 4'b0110, 64'hF0, 64'h3C, 64'hFC);
        alu_vec("xor", 2'b10, 4'b1100, 64'hF0, 64'h3C, 64'hCC);
        alu_vec("r_unlisted", 2'b10, 4'b1001, 64'hF0, 64'h3C, 64'd0);
        alu_vec("i_add_f7", 2'b11, 4'b1000, 64'd5, 64'd7, 64'd12);
        alu_vec("i_sll_f7", 2'b11, 4'b1001, 64'd1, 64'd3, 64'd8);
        alu_vec("i_srai", 2'b11, 4'b1101, 64'hFFFF_FFFF_FFFF_FF00, 64'd4, 64'hFFFF_FFFF_FFFF_FFF0);
        alu_vec("i_unlisted", 2'b11, 4'b0010, 64'd5, 64'd7, 64'd0);

        // Stall for three cycles with changing inputs
        clr();
        rs1_data_in = 64'd3; rs2_data_in = 64'd4; rd_in = 5'd11; reg_write_in = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            clr();
            stall = 1'b1; rs1_data_in = 64'd100 + 64'(i); rd_in = 5'd12; mem_write_in = 1'b1;
            tick();
            chk("stall_alu", alu_result_out, 64'd7);
            chk("stall_rd", {59'd0, rd_out}, 64'd11);
            chk("stall_ctl", {61'd0, valid_out, reg_write_out, mem_write_out}, 64'd6);
        end

        // After the stall, x11 forwards from the held EX/MEM value
        clr();
        rs_in = 5'd11; rs2_data_in = 64'd1; rd_in = 5'd13; reg_write_in = 1'b1;
        tick();
        chk("post_stall_fwd", alu_result_out, 64'd8);

        // Flush and stall together: flush wins, data held
        clr();
        flush = 1'b1; stall = 1'b1; rs1_data_in = 64'd50; reg_write_in = 1'b1;
        tick();
        chk("flush_ctl", {62'd0, valid_out, reg_write_out}, 64'd0);
        chk("flush_hold", alu_result_out, 64'd8);

        // Bubble: valid_in low drops all control
        clr();
        valid_in = 1'b0; reg_write_in = 1'b1; mem_write_in = 1'b1; mem_read_in = 1'b1;
        mem_to_reg_in = 1'b1;
        tick();
        chk("bubble_ctl", {59'd0, valid_out, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out}, 64'd0);

        // Reset while stalled clears everything
        clr();
        rs1_data_in = 64'd9; rs2_data_in = 64'd9; rd_in = 5'd14; reg_write_in = 1'b1;
        tick();
        chk("pre_rst_alu", alu_result_out, 64'd18);
        clr();
        rst = 1'b1; stall = 1'b1;
        tick();
        chk_all_zero("rst_stall");
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
